cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the hit and miss statistic counters.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 mem_read, mem_write  in  1 each  CPU request, held until mem_resp; both high is treated as a write.
REQ-005 hit0, hit1  in  1 each  per-way hit, from the tag-compare stage (tag match AND valid).
REQ-006 dirty0, dirty1  in  1 each  per-way dirty status, from the tag-compare stage (valid AND dirty).
REQ-007 lru_out  in  1  least-recently-used way of the addressed set.
REQ-008 pmem_resp  in  1  physical memory done; one-cycle pulse.
REQ-009 stat_clr  in  1  synchronous clear of both counters.
REQ-010 mem_resp  out  1  CPU request complete.
REQ-011 pmem_read, pmem_write  out  1 each  physical memory line read or writeback request.
REQ-012 load_data0/1, load_tag0/1, load_valid0/1, load_dirty0/1  out  1 each  per-way array write enables.
REQ-013 dirty_val  out  1  value written to the dirty array.
REQ-014 load_lru, lru_in  out  1 each  LRU array write enable and write value.
REQ-015 datain_sel  out  1  data-array source: 0 = CPU write merge, 1 = pmem line.
REQ-016 pmem_addr_sel  out  1  pmem address: 0 = CPU tag/index, 1 = victim tag/index.
REQ-017 hit_count, miss_count  out  CNT_W each  statistic counters.

Function
REQ-018 The block SHALL implement a three-state FSM: IDLE, WRITEBACK, ALLOCATE; all outputs other than the counters SHALL be combinational decodes of state and inputs, 0 unless stated.
REQ-019 In IDLE, with a request and (hit0 or hit1), the block SHALL assert mem_resp in the same cycle (zero-cycle hit latency) and remain in IDLE.
REQ-020 On a hit, the block SHALL assert load_lru and drive lru_in = 1 if way0 hit, else 0; if both hit, way0 SHALL take priority.
REQ-021 On a write hit, the block SHALL assert load_data and load_dirty of the hit way, with dirty_val=1 and datain_sel=0.
REQ-022 In IDLE, on a request with no hit, the block SHALL latch victim_q=lru_out and increment miss_count; next state SHALL be WRITEBACK if the victim's dirty input is 1, else ALLOCATE.
REQ-023 In WRITEBACK, the block SHALL assert pmem_write and pmem_addr_sel=1 using victim_q until pmem_resp, then go to ALLOCATE.
REQ-024 In ALLOCATE, the block SHALL assert pmem_read with pmem_addr_sel=0.
REQ-025 In the pmem_resp cycle of ALLOCATE, the block SHALL assert load_data, load_tag, load_valid and load_dirty of way victim_q, with dirty_val=0 and datain_sel=1, then go to IDLE.
REQ-026 After ALLOCATE, the request SHALL re-evaluate in IDLE as a hit; mem_resp SHALL never be asserted outside IDLE.
REQ-027 If the CPU request drops during WRITEBACK, the writeback SHALL complete, then the block SHALL return to IDLE without allocating.
REQ-028 If the CPU request drops during ALLOCATE, the refill SHALL still complete and load the arrays.
REQ-029 victim_q SHALL hold from miss detection until return to IDLE, regardless of lru_out changes.
REQ-030 hit_count SHALL increment once per mem_resp asserted on a first-time hit; a re-evaluation after a miss SHALL NOT count.
REQ-031 Both counters SHALL saturate at all-ones.
REQ-032 stat_clr SHALL zero both counters and take priority over a simultaneous increment.

Reset
REQ-033 On rst_n low, the block SHALL asynchronously force state=IDLE, victim_q=0, hit_count=0, miss_count=0, and a post-miss re-evaluation flag=0.
REQ-034 While rst_n is low, all outputs SHALL be 0 regardless of inputs.
REQ-035 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transaction, deassert pmem_read and pmem_write immediately, and perform no array loads.

Verification
REQ-036 Read hit: mem_read=1, hit1=1 -> same-cycle mem_resp=1, load_lru=1, lru_in=0, hit_count 0->1.
REQ-037 Clean read miss: lru_out=0, dirty0=0 -> ALLOCATE, pmem_read held 5 cycles until pmem_resp -> load_tag0=1, load_valid0=1, dirty_val=0 -> next cycle with hit0=1 gives mem_resp, miss_count=1, hit_count=0.
REQ-038 Dirty write miss: lru_out=1, dirty1=1 -> pmem_write with pmem_addr_sel=1 until pmem_resp -> pmem_read -> way1 loaded -> write hit with load_dirty1=1, dirty_val=1.
REQ-039 Request dropped in WRITEBACK -> pmem_write completes, no pmem_read, FSM in IDLE, no loads.
REQ-040 rst_n pulsed low mid-ALLOCATE -> pmem_read=0 immediately, counters=0, FSM in IDLE.
REQ-041 CNT_W=2, 4 hits -> hit_count saturates at 3; stat_clr together with a hit -> hit_count=0.

Source files
------------

// File: rtl/cache_control.sv
// -----------------------------------------------------------------------------
// cache_control
//
// Control FSM for a two-way set-associative, write-back, write-allocate cache.
// Hits complete in the same cycle in which they are presented. Misses first
// write back a dirty victim line if needed, then refill the victim way from
// physical memory. The request is then re-evaluated as a hit. Hit and miss
// statistic counters saturate and have a synchronous clear.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_read, mem_write     CPU request (held until mem_resp; both = write)
//   hit0/1, dirty0/1        per-way tag-compare results
//   lru_out                 LRU way of the addressed set
//   pmem_resp               physical memory done (one-cycle pulse)
//   stat_clr                synchronous clear of both statistic counters
//   mem_resp                CPU request complete
//   pmem_read, pmem_write   physical memory line refill / writeback request
//   load_*0/1, dirty_val    per-way array write enables, dirty write value
//   load_lru, lru_in        LRU array write enable and value
//   datain_sel              data source: 0 = CPU merge, 1 = pmem line
//   pmem_addr_sel           pmem address: 0 = CPU tag/index, 1 = victim
//   hit_count, miss_count   statistic counters (CNT_W bits, saturating)
// -----------------------------------------------------------------------------
module cache_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic             lru_out,
    input  logic             pmem_resp,
    input  logic             stat_clr,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             load_data0,
    output logic             load_data1,
    output logic             load_tag0,
    output logic             load_tag1,
    output logic             load_valid0,
    output logic             load_valid1,
    output logic             load_dirty0,
    output logic             load_dirty1,
    output logic             dirty_val,
    output logic             load_lru,
    output logic             lru_in,
    output logic             datain_sel,
    output logic             pmem_addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate
    } state_e;

    state_e           state_q, state_d;
    logic             victim_q, victim_d;
    // Set for the single IDLE cycle that re-evaluates a request after refill,
    // so that the completing hit is not counted as a first-time hit.
    logic             reeval_q, reeval_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;

    logic req;
    logic any_hit;
    logic victim_dirty;
    logic hit_evt;
    logic miss_evt;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    assign req          = mem_read | mem_write;
    assign any_hit      = hit0 | hit1;
    assign victim_dirty = lru_out ? dirty1 : dirty0;
    assign hit_evt      = (state_q == StIdle) & req & any_hit;
    assign miss_evt     = (state_q == StIdle) & req & ~any_hit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            victim_q     <= 1'b0;
            reeval_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            reeval_q     <= reeval_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        reeval_d = reeval_q;
        unique case (state_q)
            StIdle: begin
                reeval_d = 1'b0;
                if (miss_evt) begin
                    // Victim is frozen here; lru_out may change while we wait.
                    victim_d = lru_out;
                    state_d  = victim_dirty ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                // A dropped request finishes the writeback but skips the refill.
                if (pmem_resp) begin
                    state_d = req ? StAllocate : StIdle;
                end
            end
            StAllocate: begin
                if (pmem_resp) begin
                    state_d  = StIdle;
                    reeval_d = req;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Statistic counters: clear wins over increment, both saturate.
    // -------------------------------------------------------------------------
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (stat_clr) begin
            hit_count_d  = '0;
            miss_count_d = '0;
        end else begin
            if (hit_evt && !reeval_q && (hit_count_q != '1)) begin
                hit_count_d = hit_count_q + CntOne;
            end
            if (miss_evt && (miss_count_q != '1)) begin
                miss_count_d = miss_count_q + CntOne;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // -------------------------------------------------------------------------
    // Output decode. Everything is forced low while reset is asserted so that
    // an abandoned transaction performs no memory requests or array loads.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        load_data0    = 1'b0;
        load_data1    = 1'b0;
        load_tag0     = 1'b0;
        load_tag1     = 1'b0;
        load_valid0   = 1'b0;
        load_valid1   = 1'b0;
        load_dirty0   = 1'b0;
        load_dirty1   = 1'b0;
        dirty_val     = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        datain_sel    = 1'b0;
        pmem_addr_sel = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (hit_evt) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        // LRU points away from the way just used; way0 wins ties.
                        lru_in   = hit0;
                        if (mem_write) begin
                            if (hit0) begin
                                load_data0  = 1'b1;
                                load_dirty0 = 1'b1;
                            end else begin
                                load_data1  = 1'b1;
                                load_dirty1 = 1'b1;
                            end
                            dirty_val  = 1'b1;
                            datain_sel = 1'b0;
                        end
                    end
                end
                StWriteback: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                end
                StAllocate: begin
                    pmem_read     = 1'b1;
                    pmem_addr_sel = 1'b0;
                    if (pmem_resp) begin
                        if (victim_q) begin
                            load_data1  = 1'b1;
                            load_tag1   = 1'b1;
                            load_valid1 = 1'b1;
                            load_dirty1 = 1'b1;
                        end else begin
                            load_data0  = 1'b1;
                            load_tag0   = 1'b1;
                            load_valid0 = 1'b1;
                            load_dirty0 = 1'b1;
                        end
                        dirty_val  = 1'b0;
                        datain_sel = 1'b1;
                    end
                end
                default: begin
                    mem_resp = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// -----------------------------------------------------------------------------
// tb_cache_control
//
// Self-checking bench for cache_control. Directed scenarios plus randomized
// transactions; expected behaviour is derived per transaction from the cache
// protocol (hit / writeback / refill / re-evaluate) and plain hit/miss tallies.
// A second instance with CNT_W = 2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_cache_control;

    typedef struct packed {
        logic mem_resp;
        logic pmem_read;
        logic pmem_write;
        logic load_data0;
        logic load_data1;
        logic load_tag0;
        logic load_tag1;
        logic load_valid0;
        logic load_valid1;
        logic load_dirty0;
        logic load_dirty1;
        logic dirty_val;
        logic load_lru;
        logic lru_in;
        logic datain_sel;
        logic pmem_addr_sel;
    } out_t;

    logic clk;
    logic rst_n;
    logic mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru_out, pmem_resp, stat_clr;

    logic mem_resp, pmem_read, pmem_write, load_data0, load_data1, load_tag0, load_tag1;
    logic load_valid0, load_valid1, load_dirty0, load_dirty1, dirty_val, load_lru, lru_in;
    logic datain_sel, pmem_addr_sel;
    logic [15:0] hit_count, miss_count;

    logic m2_resp, m2_pread, m2_pwrite, m2_ld0, m2_ld1, m2_lt0, m2_lt1, m2_lv0, m2_lv1;
    logic m2_ldy0, m2_ldy1, m2_dval, m2_llru, m2_lru_in, m2_dsel, m2_asel;
    logic [1:0] hit_count2, miss_count2;

    out_t obs, obs2, e;

    int n_checks;
    int n_fail;
    int exp_hits;
    int exp_misses;

    assign obs = {mem_resp, pmem_read, pmem_write, load_data0, load_data1, load_tag0, load_tag1,
                  load_valid0, load_valid1, load_dirty0, load_dirty1, dirty_val, load_lru,
                  lru_in, datain_sel, pmem_addr_sel};
    assign obs2 = {m2_resp, m2_pread, m2_pwrite, m2_ld0, m2_ld1, m2_lt0, m2_lt1, m2_lv0, m2_lv1,
                   m2_ldy0, m2_ldy1, m2_dval, m2_llru, m2_lru_in, m2_dsel, m2_asel};

    cache_control #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1), .lru_out(lru_out),
        .pmem_resp(pmem_resp), .stat_clr(stat_clr), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .load_data0(load_data0),
        .load_data1(load_data1), .load_tag0(load_tag0), .load_tag1(load_tag1),
        .load_valid0(load_valid0), .load_valid1(load_valid1), .load_dirty0(load_dirty0),
        .load_dirty1(load_dirty1), .dirty_val(dirty_val), .load_lru(load_lru),
        .lru_in(lru_in), .datain_sel(datain_sel), .pmem_addr_sel(pmem_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_control #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1), .lru_out(lru_out),
        .pmem_resp(pmem_resp), .stat_clr(stat_clr), .mem_resp(m2_resp),
        .pmem_read(m2_pread), .pmem_write(m2_pwrite), .load_data0(m2_ld0),
        .load_data1(m2_ld1), .load_tag0(m2_lt0), .load_tag1(m2_lt1),
        .load_valid0(m2_lv0), .load_valid1(m2_lv1), .load_dirty0(m2_ldy0),
        .load_dirty1(m2_ldy1), .dirty_val(m2_dval), .load_lru(m2_llru),
        .lru_in(m2_lru_in), .datain_sel(m2_dsel), .pmem_addr_sel(m2_asel),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {hit16, miss16, hit2, miss2} from the running tallies.
    function automatic logic [35:0] exp_cnt(input int h, input int m);
        int h16, m16, h2, m2;
        h16 = (h > 65535) ? 65535 : h;
        m16 = (m > 65535) ? 65535 : m;
        h2  = (h > 3) ? 3 : h;
        m2  = (m > 3) ? 3 : m;
        return {h16[15:0], m16[15:0], h2[1:0], m2[1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        dirty0    = 1'b0;
        dirty1    = 1'b0;
        lru_out   = 1'b0;
        pmem_resp = 1'b0;
        stat_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        mem_read = 1'b1; mem_write = 1'b1; hit0 = 1'b1; dirty1 = 1'b1; pmem_resp = 1'b1;
        #2;
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_outs got %b want 0", obs);
        end
        n_checks++;
        if ({hit_count, miss_count, hit_count2, miss_count2} !== 36'd0) begin
            n_fail++; $display("FAIL reset_cnt got %h want 0", {hit_count, miss_count});
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        exp_hits = 0; exp_misses = 0;
        tick();
    endtask

    task automatic test_read_hit();
        mem_read = 1'b1; hit1 = 1'b1;
        #2;
        e = '0; e.mem_resp = 1'b1; e.load_lru = 1'b1; e.lru_in = 1'b0;
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL read_hit got %b want %b", obs, e);
        end
        tick();
        exp_hits++;
        idle_inputs();
        n_checks++;
        if ({hit_count, miss_count, hit_count2, miss_count2} !== exp_cnt(exp_hits, exp_misses))
        begin
            n_fail++; $display("FAIL read_hit_cnt got %0d want %0d", hit_count, exp_hits);
        end
    endtask

    task automatic test_clean_read_miss();
        mem_read = 1'b1; lru_out = 1'b0; dirty0 = 1'b0; dirty1 = 1'b1;
        #2;
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL clean_miss_idle got %b want 0", obs);
        end
        tick();
        exp_misses++;
        lru_out = 1'b1;  // victim must stay way0
        for (int c = 1; c <= 5; c++) begin
            pmem_resp = (c == 5);
            #2;
            e = '0; e.pmem_read = 1'b1;
            if (c == 5) begin
                e.load_data0 = 1'b1; e.load_tag0 = 1'b1; e.load_valid0 = 1'b1;
                e.load_dirty0 = 1'b1; e.datain_sel = 1'b1;
            end
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL clean_miss_alloc c=%0d got %b want %b", c, obs, e);
            end
            tick();
        end
        pmem_resp = 1'b0; hit0 = 1'b1;
        #2;
        e = '0; e.mem_resp = 1'b1; e.load_lru = 1'b1; e.lru_in = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL clean_miss_reeval got %b want %b", obs, e);
        end
        tick();
        idle_inputs();
        n_checks++;
        if ({hit_count, miss_count, hit_count2, miss_count2} !== exp_cnt(exp_hits, exp_misses))
        begin
            n_fail++; $display("FAIL clean_miss_cnt got %0d/%0d want %0d/%0d",
                               hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_dirty_write_miss();
        mem_write = 1'b1; lru_out = 1'b1; dirty1 = 1'b1; dirty0 = 1'b0;
        tick();
        exp_misses++;
        lru_out = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            pmem_resp = (c == 3);
            #2;
            e = '0; e.pmem_write = 1'b1; e.pmem_addr_sel = 1'b1;
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL dirty_miss_wb c=%0d got %b want %b", c, obs, e);
            end
            tick();
        end
        for (int c = 1; c <= 2; c++) begin
            pmem_resp = (c == 2);
            #2;
            e = '0; e.pmem_read = 1'b1;
            if (c == 2) begin
                e.load_data1 = 1'b1; e.load_tag1 = 1'b1; e.load_valid1 = 1'b1;
                e.load_dirty1 = 1'b1; e.datain_sel = 1'b1;
            end
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL dirty_miss_alloc c=%0d got %b want %b", c, obs, e);
            end
            tick();
        end
        pmem_resp = 1'b0; hit1 = 1'b1;
        #2;
        e = '0; e.mem_resp = 1'b1; e.load_lru = 1'b1; e.load_data1 = 1'b1;
        e.load_dirty1 = 1'b1; e.dirty_val = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL dirty_miss_write_hit got %b want %b", obs, e);
        end
        tick();
        idle_inputs();
        n_checks++;
        if ({hit_count, miss_count, hit_count2, miss_count2} !== exp_cnt(exp_hits, exp_misses))
        begin
            n_fail++; $display("FAIL dirty_miss_cnt got %0d/%0d want %0d/%0d",
                               hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_drop_in_writeback();
        mem_read = 1'b1; lru_out = 1'b0; dirty0 = 1'b1;
        tick();
        exp_misses++;
        mem_read = 1'b0; dirty0 = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            pmem_resp = (c == 2);
            #2;
            e = '0; e.pmem_write = 1'b1; e.pmem_addr_sel = 1'b1;
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL drop_wb c=%0d got %b want %b", c, obs, e);
            end
            tick();
        end
        pmem_resp = 1'b0;
        #2;
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL drop_wb_after got %b want 0", obs);
        end
        // A fresh hit must complete at once and count as a first-time hit.
        mem_read = 1'b1; hit0 = 1'b1;
        #2;
        e = '0; e.mem_resp = 1'b1; e.load_lru = 1'b1; e.lru_in = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL drop_wb_idle_hit got %b want %b", obs, e);
        end
        tick();
        exp_hits++;
        idle_inputs();
        n_checks++;
        if ({hit_count, miss_count, hit_count2, miss_count2} !== exp_cnt(exp_hits, exp_misses))
        begin
            n_fail++; $display("FAIL drop_wb_cnt got %0d/%0d want %0d/%0d",
                               hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset_mid_allocate();
        mem_read = 1'b1; lru_out = 1'b1; dirty1 = 1'b0;
        tick();
        exp_misses++;
        #2;
        e = '0; e.pmem_read = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL rst_alloc_pre got %b want %b", obs, e);
        end
        rst_n = 1'b0; pmem_resp = 1'b1;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL rst_alloc_outs got %b want 0", obs);
        end
        exp_hits = 0; exp_misses = 0;
        n_checks++;
        if ({hit_count, miss_count, hit_count2, miss_count2} !== exp_cnt(exp_hits, exp_misses))
        begin
            n_fail++; $display("FAIL rst_alloc_cnt got %0d/%0d want 0/0", hit_count, miss_count);
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        mem_read = 1'b1; hit1 = 1'b1;
        #2;
        e = '0; e.mem_resp = 1'b1; e.load_lru = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL rst_alloc_idle_hit got %b want %b", obs, e);
        end
        tick();
        exp_hits++;
        idle_inputs();
    endtask

    task automatic test_saturation();
        stat_clr = 1'b1;
        tick();
        exp_hits = 0; exp_misses = 0;
        stat_clr = 1'b0; mem_read = 1'b1; hit0 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            e = '0; e.mem_resp = 1'b1; e.load_lru = 1'b1; e.lru_in = 1'b1;
            n_checks++;
            if (obs2 !== e) begin
                n_fail++; $display("FAIL sat_hit c=%0d got %b want %b", c, obs2, e);
            end
            tick();
            exp_hits++;
        end
        n_checks++;
        if (hit_count2 !== 2'd3 || hit_count !== 16'(exp_hits)) begin
            n_fail++; $display("FAIL sat_hit_cnt got %0d/%0d want 3/%0d",
                               hit_count2, hit_count, exp_hits);
        end
        stat_clr = 1'b1;
        tick();
        exp_hits = 0; exp_misses = 0;
        idle_inputs();
        n_checks++;
        if ({hit_count, miss_count, hit_count2, miss_count2} !== exp_cnt(exp_hits, exp_misses))
        begin
            n_fail++; $display("FAIL sat_clr_priority got %0d/%0d want 0/0",
                               hit_count2, hit_count);
        end
    endtask

    // Random transactions: hit, or miss with optional writeback and drops.
    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int  op, hs, lat_wb, lat_al;
            bit  wr, h0, h1, lru, d0, d1, vdirty, drop_wb, drop_al, dropped;
            op      = int'($urandom_range(0, 2));
            hs      = int'($urandom_range(0, 3));
            lru     = 1'($urandom);
            d0      = 1'($urandom);
            d1      = 1'($urandom);
            lat_wb  = int'($urandom_range(1, 4));
            lat_al  = int'($urandom_range(1, 4));
            drop_wb = ($urandom_range(0, 3) == 0);
            drop_al = ($urandom_range(0, 3) == 0);
            wr      = (op != 0);
            h0      = hs[0];
            h1      = hs[1];
            mem_read  = (op != 1);
            mem_write = wr;
            hit0 = h0; hit1 = h1; lru_out = lru; dirty0 = d0; dirty1 = d1;
            #2;
            e = '0;
            if (h0 || h1) begin
                e.mem_resp = 1'b1; e.load_lru = 1'b1; e.lru_in = h0;
                if (wr) begin
                    e.dirty_val = 1'b1;
                    if (h0) begin
                        e.load_data0 = 1'b1; e.load_dirty0 = 1'b1;
                    end else begin
                        e.load_data1 = 1'b1; e.load_dirty1 = 1'b1;
                    end
                end
            end
            n_checks++;
            if (obs !== e) begin
                n_fail++; $display("FAIL rnd_first t=%0d got %b want %b", t, obs, e);
            end
            tick();
            if (h0 || h1) exp_hits++;
            else exp_misses++;
            if (!(h0 || h1)) begin
                vdirty  = lru ? d1 : d0;
                dropped = 1'b0;
                hit0 = 1'b0; hit1 = 1'b0;
                lru_out = ~lru;
                if (vdirty) begin
                    for (int c = 1; c <= lat_wb; c++) begin
                        if (drop_wb && c == 1) begin
                            mem_read = 1'b0; mem_write = 1'b0; dropped = 1'b1;
                        end
                        pmem_resp = (c == lat_wb);
                        #2;
                        e = '0; e.pmem_write = 1'b1; e.pmem_addr_sel = 1'b1;
                        n_checks++;
                        if (obs !== e) begin
                            n_fail++; $display("FAIL rnd_wb t=%0d got %b want %b", t, obs, e);
                        end
                        tick();
                    end
                    pmem_resp = 1'b0;
                end
                if (!dropped) begin
                    for (int c = 1; c <= lat_al; c++) begin
                        if (drop_al && c == 1) begin
                            mem_read = 1'b0; mem_write = 1'b0; dropped = 1'b1;
                        end
                        pmem_resp = (c == lat_al);
                        #2;
                        e = '0; e.pmem_read = 1'b1;
                        if (c == lat_al) begin
                            e.datain_sel = 1'b1;
                            if (lru) begin
                                e.load_data1 = 1'b1; e.load_tag1 = 1'b1;
                                e.load_valid1 = 1'b1; e.load_dirty1 = 1'b1;
                            end else begin
                                e.load_data0 = 1'b1; e.load_tag0 = 1'b1;
                                e.load_valid0 = 1'b1; e.load_dirty0 = 1'b1;
                            end
                        end
                        n_checks++;
                        if (obs !== e) begin
                            n_fail++; $display("FAIL rnd_alloc t=%0d got %b want %b", t, obs, e);
                        end
                        tick();
                    end
                    pmem_resp = 1'b0;
                end
                e = '0;
                if (!dropped) begin
                    hit0 = ~lru; hit1 = lru;
                    e.mem_resp = 1'b1; e.load_lru = 1'b1; e.lru_in = ~lru;
                    if (wr) begin
                        e.dirty_val = 1'b1;
                        if (lru) begin
                            e.load_data1 = 1'b1; e.load_dirty1 = 1'b1;
                        end else begin
                            e.load_data0 = 1'b1; e.load_dirty0 = 1'b1;
                        end
                    end
                end
                #2;
                n_checks++;
                if (obs !== e) begin
                    n_fail++; $display("FAIL rnd_end t=%0d got %b want %b", t, obs, e);
                end
                tick();
            end
            idle_inputs();
            n_checks++;
            if ({hit_count, miss_count, hit_count2, miss_count2} !== exp_cnt(exp_hits, exp_misses))
            begin
                n_fail++; $display("FAIL rnd_cnt t=%0d got %0d/%0d/%0d/%0d want %0d/%0d", t,
                                   hit_count, miss_count, hit_count2, miss_count2,
                                   exp_hits, exp_misses);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_hits   = 0;
        exp_misses = 0;
        test_reset();
        test_read_hit();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_drop_in_writeback();
        test_reset_mid_allocate();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
